mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS core. Sequences fetch, decode, execute, memory and write-back over several cycles and drives the datapath enables. It generates the 2-bit register-destination select consumed by the destination-register mux (00 = rt, 01 = rd, 10 = $31). It also owns the memory request handshake and the start/done handshake with the multi-cycle divider.

---
 rtl/mc_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/writeback sequencing, memory and divider handshakes.
// Optional illegal-instruction trap enabled by defining MC_CTRL_TRAP_EN.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    input  logic       div_done,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [2:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst_sel,
    output logic [1:0] wb_src,
    output logic       alu_src_b,
    output logic       div_start,
    output logic       exc,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXEC     = 3'd2,
        MEM      = 3'd3,
        WB       = 3'd4,
        DIV_WAIT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_RALU, CLS_HILO, CLS_IALU, CLS_LW, CLS_SW, CLS_BEQ,
        CLS_BNE, CLS_J, CLS_JAL, CLS_JR, CLS_DIV, CLS_ILL
    } cls_t;

    state_t state_q, state_d;
    cls_t   cls;

    // IR is stable from DECODE onward, so the class is decoded live rather than latched.
    always_comb begin
        cls = CLS_ILL;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:          cls = CLS_RALU;
                    6'h10, 6'h12:          cls = CLS_HILO;
                    6'h08:                 cls = CLS_JR;
                    6'h1A, 6'h1B:          cls = CLS_DIV;
                    default:               cls = CLS_ILL;
                endcase
            end
            6'h02:                         cls = CLS_J;
            6'h03:                         cls = CLS_JAL;
            6'h04:                         cls = CLS_BEQ;
            6'h05:                         cls = CLS_BNE;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:    cls = CLS_IALU;
            6'h23:                         cls = CLS_LW;
            6'h2B:                         cls = CLS_SW;
            default:                       cls = CLS_ILL;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 3'd0;
        reg_we      = 1'b0;
        reg_dst_sel = 2'b00;
        wb_src      = 2'b00;
        alu_src_b   = 1'b0;
        div_start   = 1'b0;
        exc         = 1'b0;
        state       = state_q;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (cls == CLS_ILL) begin
`ifdef MC_CTRL_TRAP_EN
                    exc    = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = 3'd4;
`endif
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                case (cls)
                    CLS_RALU, CLS_HILO: state_d = WB;
                    CLS_IALU: begin
                        alu_src_b = 1'b1;
                        state_d   = WB;
                    end
                    CLS_LW, CLS_SW: begin
                        alu_src_b = 1'b1;
                        state_d   = MEM;
                    end
                    CLS_BEQ: begin
                        pc_we  = alu_zero;
                        pc_src = alu_zero ? 3'd1 : 3'd0;
                    end
                    CLS_BNE: begin
                        pc_we  = ~alu_zero;
                        pc_src = alu_zero ? 3'd0 : 3'd1;
                    end
                    CLS_J: begin
                        pc_we  = 1'b1;
                        pc_src = 3'd2;
                    end
                    CLS_JR: begin
                        pc_we  = 1'b1;
                        pc_src = 3'd3;
                    end
                    CLS_JAL: state_d = WB;
                    CLS_DIV: begin
                        div_start = 1'b1;
                        state_d   = DIV_WAIT;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (cls == CLS_SW);
                if (mem_ready)
                    state_d = (cls == CLS_SW) ? FETCH : WB;
            end
            WB: begin
                reg_we  = 1'b1;
                state_d = FETCH;
                case (cls)
                    CLS_RALU: reg_dst_sel = 2'b01;
                    CLS_HILO: begin
                        reg_dst_sel = 2'b01;
                        wb_src      = 2'b11;
                    end
                    CLS_LW:   wb_src = 2'b01;
                    CLS_JAL: begin
                        reg_dst_sel = 2'b10;
                        wb_src      = 2'b10;
                        pc_we       = 1'b1;
                        pc_src      = 3'd2;
                    end
                    default: ;
                endcase
            end
            DIV_WAIT: begin
                if (div_done)
                    state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset forces every output low, including the FETCH request of the reset state.
        if (!rst_n) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            iord        = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 3'd0;
            reg_we      = 1'b0;
            reg_dst_sel = 2'b00;
            wb_src      = 2'b00;
            alu_src_b   = 1'b0;
            div_start   = 1'b0;
            exc         = 1'b0;
            state       = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through the FSM and checks every output per cycle.
module tb_mc_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready, div_done;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_src_b, div_start, exc;
    logic [2:0] pc_src, state;
    logic [1:0] reg_dst_sel, wb_src;

    int n_checks = 0;
    int n_fail   = 0;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .div_done(div_done),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst_sel(reg_dst_sel), .wb_src(wb_src), .alu_src_b(alu_src_b),
        .div_start(div_start), .exc(exc), .state(state)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we,
                  reg_dst_sel, wb_src, alu_src_b, div_start, exc};

    // Expected vector: state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, dst, wb, alu_src_b, div_start, exc
    function automatic logic [18:0] ev(input logic [2:0] st, input logic mr, input logic mw,
                                       input logic io, input logic irw, input logic pcw,
                                       input logic [2:0] ps, input logic rw, input logic [1:0] rd,
                                       input logic [1:0] wb, input logic asb, input logic ds,
                                       input logic ex);
        return {st, mr, mw, io, irw, pcw, ps, rw, rd, wb, asb, ds, ex};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [18:0] expv);
        #1;
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    localparam logic [18:0] FETCH_GO = 19'h0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0; div_done = 1'b0;
        opcode = 6'h00; funct = 6'h20;

        repeat (3) begin
            tick();
            check("reset", ev(3'd0, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        end
        rst_n = 1'b1;
        check("fetch_release", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // add
        tick(); check("add_decode", ev(3'd1, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("add_exec",   ev(3'd2, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("add_wb",     ev(3'd4, 0,0,0,0,0, 3'd0, 1, 2'd1, 2'd0, 0,0,0));
        tick(); opcode = 6'h23;
        check("add_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // lw with three wait cycles in MEM
        tick(); check("lw_decode", ev(3'd1, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("lw_exec",   ev(3'd2, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 1,0,0));
        tick(); mem_ready = 1'b0;
        check("lw_mem_wait0", ev(3'd3, 1,0,1,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("lw_mem_wait1", ev(3'd3, 1,0,1,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("lw_mem_wait2", ev(3'd3, 1,0,1,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); mem_ready = 1'b1;
        check("lw_mem_ready", ev(3'd3, 1,0,1,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("lw_wb", ev(3'd4, 0,0,0,0,0, 3'd0, 1, 2'd0, 2'd1, 0,0,0));
        tick(); opcode = 6'h2B;
        check("lw_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // sw
        tick(); check("sw_decode", ev(3'd1, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("sw_exec",   ev(3'd2, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 1,0,0));
        tick(); check("sw_mem",    ev(3'd3, 1,1,1,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); opcode = 6'h04; alu_zero = 1'b1;
        check("sw_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // beq taken, bne not taken
        tick(); check("beq_decode", ev(3'd1, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("beq_exec",   ev(3'd2, 0,0,0,0,1, 3'd1, 0, 2'd0, 2'd0, 0,0,0));
        tick(); opcode = 6'h05;
        check("beq_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); tick();
        check("bne_exec", ev(3'd2, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); opcode = 6'h02; alu_zero = 1'b0;
        check("bne_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // j, then jr
        tick(); tick();
        check("j_exec", ev(3'd2, 0,0,0,0,1, 3'd2, 0, 2'd0, 2'd0, 0,0,0));
        tick(); opcode = 6'h00; funct = 6'h08;
        check("j_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); tick();
        check("jr_exec", ev(3'd2, 0,0,0,0,1, 3'd3, 0, 2'd0, 2'd0, 0,0,0));
        tick(); opcode = 6'h03;
        check("jr_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // jal
        tick(); tick();
        check("jal_exec", ev(3'd2, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("jal_wb", ev(3'd4, 0,0,0,0,1, 3'd2, 1, 2'd2, 2'd2, 0,0,0));
        tick(); opcode = 6'h00; funct = 6'h10;
        check("jal_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // mfhi
        tick(); tick(); tick();
        check("mfhi_wb", ev(3'd4, 0,0,0,0,0, 3'd0, 1, 2'd1, 2'd3, 0,0,0));
        tick(); funct = 6'h1A;
        check("mfhi_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // div: done during EXEC must be ignored
        tick(); tick(); div_done = 1'b1;
        check("div_exec", ev(3'd2, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,1,0));
        tick(); div_done = 1'b0;
        check("div_wait0", ev(3'd5, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("div_wait1", ev(3'd5, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); div_done = 1'b1;
        check("div_wait_done", ev(3'd5, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); div_done = 1'b0; opcode = 6'h3F;
        check("div_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // illegal opcode
        tick();
`ifdef MC_CTRL_TRAP_EN
        check("ill_decode", ev(3'd1, 0,0,0,0,1, 3'd4, 0, 2'd0, 2'd0, 0,0,1));
`else
        check("ill_decode", ev(3'd1, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
`endif
        tick(); opcode = 6'h23;
        check("ill_next_fetch", ev(3'd0, 1,0,0,1,1, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        // reset while lw waits in MEM
        tick(); tick(); tick(); mem_ready = 1'b0;
        check("rstmem_mem", ev(3'd3, 1,0,1,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        rst_n = 1'b0;
        tick(); check("rstmem_reset", ev(3'd0, 0,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        rst_n = 1'b1;
        check("rstmem_release", ev(3'd0, 1,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));
        tick(); check("fetch_hold", ev(3'd0, 1,0,0,0,0, 3'd0, 0, 2'd0, 2'd0, 0,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
